// File: rtl/gpc_pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
// Holds the FSM state encoding, the redirect-source encoding and the alignment mask helper.
package gpc_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_SEQ  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_e;

    // Mask with the low 'bits' bits set (e.g. bits=2 -> 'b11); callers truncate to their width.
    function automatic logic [63:0] align_mask(input int unsigned bits);
        align_mask = (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc selection: trap > branch > sequential > hold.
// Optional feature macro PC_MISALIGN_CHK_EN: misaligned branch targets are diverted to
// trap_target and flagged; without it, the low alignment bits of targets are cleared on load.
module pc_next_sel
    import gpc_pc_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned ALIGN_BITS  = 2
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             fire,
    input  logic             trap_req,
    input  logic [WIDTH-1:0] trap_target,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect,
    output logic             misalign_hit
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(ALIGN_BITS));
    localparam logic [WIDTH-1:0] PC_INC   = WIDTH'(INSTR_BYTES);

    redir_src_e src_s;

    // Fixed-priority choice of where the next pc comes from.
    always_comb begin
        src_s = SRC_NONE;
        if (trap_req) begin
            src_s = SRC_TRAP;
        end else if (br_req) begin
            src_s = SRC_BR;
        end else if (fire) begin
            src_s = SRC_SEQ;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // Build the next pc for the chosen source; the increment wraps modulo 2^WIDTH.
    always_comb begin
        next_pc      = pc;
        redirect     = 1'b0;
        misalign_hit = 1'b0;
        case (src_s)
`ifdef PC_MISALIGN_CHK_EN
            SRC_TRAP: begin
                next_pc  = trap_target;
                redirect = 1'b1;
            end
            SRC_BR: begin
                redirect = 1'b1;
                if ((br_target & LOW_MASK) != {WIDTH{1'b0}}) begin
                    next_pc      = trap_target;
                    misalign_hit = 1'b1;
                end else begin
                    next_pc = br_target;
                end
            end
`else
            SRC_TRAP: begin
                next_pc  = trap_target & ~LOW_MASK;
                redirect = 1'b1;
            end
            SRC_BR: begin
                next_pc  = br_target & ~LOW_MASK;
                redirect = 1'b1;
            end
`endif
            SRC_SEQ: begin
                next_pc = pc + PC_INC;
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: BOOT/RUN/HALT state machine plus output registers.
// Optional feature macro PC_MISALIGN_CHK_EN enables misaligned-branch trapping (see pc_next_sel).
module pc_unit
    import gpc_pc_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  START_ADDR  = 32'h8000_0000,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter int unsigned       ALIGN_BITS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_ready,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             misalign
);

    pc_state_e        state_r;
    pc_state_e        state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic             pc_valid_r;
    logic             flush_r;
    logic             misalign_r;
    logic             fire_s;
    logic             trap_req_s;
    logic             br_req_s;
    logic [WIDTH-1:0] next_pc_s;
    logic             redirect_s;
    logic             misalign_hit_s;

    // Handshake and request qualification: branches only in RUN, traps in RUN or HALT.
    always_comb begin
        fire_s     = pc_valid_r & pc_ready;
        trap_req_s = trap_valid & (state_r != ST_BOOT);
        br_req_s   = br_valid & (state_r == ST_RUN);
    end

    pc_next_sel #(
        .WIDTH       (WIDTH),
        .INSTR_BYTES (INSTR_BYTES),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_next_sel (
        .pc           (pc_r),
        .fire         (fire_s),
        .trap_req     (trap_req_s),
        .trap_target  (trap_target),
        .br_req       (br_req_s),
        .br_target    (br_target),
        .next_pc      (next_pc_s),
        .redirect     (redirect_s),
        .misalign_hit (misalign_hit_s)
    );

    // Next-state logic: a trap always lands in RUN and swallows a same-cycle halt request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (trap_valid) begin
                    state_nxt_s = ST_RUN;
                end else if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (trap_valid || resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= START_ADDR;
            pc_valid_r <= 1'b0;
            flush_r    <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= next_pc_s;
            pc_valid_r <= (state_nxt_s == ST_RUN);
            flush_r    <= redirect_s;
            misalign_r <= misalign_hit_s;
        end
    end

    assign pc       = pc_r;
    assign pc_valid = pc_valid_r;
    assign flush    = flush_r;
    assign misalign = misalign_r;

endmodule
